// File: rtl/seq_det_pkg.sv
// Shared types and reset-time configuration for the programmable sequence detector.
package seq_det_pkg;

  // FILL: fewer than len bits accepted since the last clear.
  // ARMED: at least len bits accepted, so every new bit can complete a match.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Out of reset the block looks for "101" with overlap enabled.
  localparam logic [31:0] DEF_PATTERN = 32'h0000_0005;
  localparam int unsigned DEF_LEN     = 3;
  localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime pattern/length/overlap,
// registered match pulse, saturating match counter and config-error pulse.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);

  localparam int LW = $clog2(MAX_LEN+1);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt;
  logic [LW-1:0]      fill, fill_nxt;
  logic [MAX_LEN-1:0] pat, pat_nxt;
  logic [LW-1:0]      len, len_nxt;
  logic               ovl, ovl_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               out_nxt, err_nxt;

  logic [MAX_LEN-1:0] hist_sh;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               cfg_ok;
  logic               reached;
  logic               hit;

  // Datapath helpers: shifted history, saturating fill, and the active-length mask
  // that hides pattern/history bits above len-1 from the comparison.
  always_comb begin
    hist_sh  = {hist[MAX_LEN-2:0], in};
    fill_inc = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LW'(i) < len);
    cfg_ok   = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));
    // ARMED already implies fill >= len; in FILL we become eligible only
    // when this bit brings fill up to len.
    reached  = (state == ARMED) || (fill_inc >= len);
    hit      = reached && ((hist_sh & mask) == (pat & mask));
  end

  // Next-state / output logic; cfg_load outranks in_valid and swallows the bit.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    pat_nxt   = pat;
    len_nxt   = len;
    ovl_nxt   = ovl;
    cnt_nxt   = match_cnt;
    out_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_nxt   = cfg_pattern;
        len_nxt   = cfg_len;
        ovl_nxt   = cfg_overlap;
        hist_nxt  = '0;
        fill_nxt  = '0;
        cnt_nxt   = '0;
        state_nxt = FILL;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (in_valid) begin
      hist_nxt = hist_sh;
      fill_nxt = fill_inc;
      case (state)
        FILL:    if (reached) state_nxt = ARMED;
        ARMED:   state_nxt = ARMED;
        default: state_nxt = FILL;
      endcase
      if (hit) begin
        out_nxt = 1'b1;
        if (!(&match_cnt)) cnt_nxt = match_cnt + 1'b1;
        // Non-overlapping: the matched bits cannot seed the next match.
        if (!ovl) begin
          fill_nxt  = '0;
          state_nxt = FILL;
        end
      end
    end
  end

  // State register; reset restores the default 101 overlapping configuration.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= FILL;
      hist      <= '0;
      fill      <= '0;
      pat       <= MAX_LEN'(DEF_PATTERN);
      len       <= LW'(DEF_LEN);
      ovl       <= DEF_OVERLAP;
      match_cnt <= '0;
      out       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      pat       <= pat_nxt;
      len       <= len_nxt;
      ovl       <= ovl_nxt;
      match_cnt <= cnt_nxt;
      out       <= out_nxt;
      cfg_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus a randomized run against a
// queue-based reference model of "last len accepted bits equal the pattern".
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_b = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       out, cfg_err, out2, cfg_err2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in(in_b), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out), .match_cnt(match_cnt), .cfg_err(cfg_err));

  // Narrow-counter copy fed the same stimulus, for saturation checks.
  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in(in_b), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out2), .match_cnt(match_cnt2), .cfg_err(cfg_err2));

  // Reference model
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt, m_cnt2;
  bit         m_out, m_err;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    q.delete();
    m_pat = 8'b101; m_len = 3; m_ovl = 1'b1;
    m_cnt = 0; m_cnt2 = 0; m_out = 1'b0; m_err = 1'b0;
  endfunction

  // Drive one cycle, advance the model, leave outputs ready to sample.
  task automatic step(input bit v, input bit b, input bit ld = 1'b0,
                      input logic [7:0] p = 8'h00, input int l = 0, input bit ov = 1'b0);
    bit eq;
    in_valid = v; in_b = b; cfg_load = ld; cfg_pattern = p; cfg_len = l[3:0]; cfg_overlap = ov;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0;
    m_out = 1'b0; m_err = 1'b0;
    if (ld) begin
      if (l >= 2 && l <= MAX_LEN) begin
        m_pat = p; m_len = l; m_ovl = ov; q.delete(); m_cnt = 0; m_cnt2 = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (v) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (q.size() >= m_len) begin
        eq = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size()-m_len+k] != m_pat[m_len-1-k]) eq = 1'b0;
        if (eq) begin
          m_out = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ovl) q.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    arst = 1'b0;
    @(posedge clk); #1;
    arst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    arst = 1'b0; #3;
    n_checks++;
    if (out !== 1'b0 || cfg_err !== 1'b0 || match_cnt !== 16'd0 || match_cnt2 !== 2'd0)
      $display("FAIL reset_outputs out=%b err=%b cnt=%0d cnt2=%0d, expected all 0",
               out, cfg_err, match_cnt, match_cnt2);
    else n_pass++;
    @(posedge clk); #1;
    arst = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    n_checks++;
    if (out !== 1'b0 || match_cnt !== 16'd0)
      $display("FAIL reset_idle out=%b cnt=%0d, expected 0/0", out, match_cnt);
    else n_pass++;
  endtask

  task automatic test_default_overlap();
    bit s[7]   = '{1,0,1,0,1,0,1};
    bit exp[7] = '{0,0,1,0,1,0,1};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[i]);
      n_checks++;
      if (out !== exp[i] || out !== m_out)
        $display("FAIL default_overlap bit%0d out=%b expected %b", i+1, out, exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (match_cnt !== 16'd3) $display("FAIL default_overlap_cnt got %0d expected 3", match_cnt);
    else n_pass++;
  endtask

  task automatic test_nonoverlap();
    bit s[7]   = '{1,0,1,0,1,0,1};
    bit exp[7] = '{0,0,1,0,0,0,1};
    step(1'b0, 1'b0, 1'b1, 8'b101, 3, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0 || match_cnt !== 16'd0)
      $display("FAIL nonoverlap_load err=%b cnt=%0d expected 0/0", cfg_err, match_cnt);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[i]);
      n_checks++;
      if (out !== exp[i])
        $display("FAIL nonoverlap bit%0d out=%b expected %b", i+1, out, exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (match_cnt !== 16'd2) $display("FAIL nonoverlap_cnt got %0d expected 2", match_cnt);
    else n_pass++;
  endtask

  task automatic test_len8_gap();
    bit s[8] = '{1,0,1,0,0,1,0,1};
    int pulses = 0;
    step(1'b0, 1'b0, 1'b1, 8'hA5, 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i]);
      n_checks++;
      if (out !== (i == 7))
        $display("FAIL len8 bit%0d out=%b expected %b", i+1, out, (i == 7));
      else n_pass++;
      if (out) pulses++;
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'($urandom_range(0, 1)));
          n_checks++;
          if (out !== 1'b0) $display("FAIL len8_gap cycle%0d out=%b expected 0", g, out);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses != 1 || match_cnt !== 16'd1)
      $display("FAIL len8_total pulses=%0d cnt=%0d expected 1/1", pulses, match_cnt);
    else n_pass++;
  endtask

  task automatic test_bad_cfg();
    int bad[2] = '{0, 9};
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    for (int j = 0; j < 2; j++) begin
      step(1'b0, 1'b0, 1'b1, 8'($urandom), bad[j], 1'b0);
      n_checks++;
      if (cfg_err !== 1'b1 || match_cnt !== 16'd1)
        $display("FAIL bad_cfg len%0d err=%b cnt=%0d expected 1/1", bad[j], cfg_err, match_cnt);
      else n_pass++;
      step(1'b0, 1'b0);
      n_checks++;
      if (cfg_err !== 1'b0) $display("FAIL bad_cfg_pulse len%0d err=%b expected 0", bad[j], cfg_err);
      else n_pass++;
    end
    step(1'b1, 1'b0); step(1'b1, 1'b1);
    n_checks++;
    if (out !== 1'b1 || match_cnt !== 16'd2)
      $display("FAIL bad_cfg_keeps out=%b cnt=%0d expected 1/2", out, match_cnt);
    else n_pass++;
  endtask

  task automatic test_cfg_priority();
    // Load "11" while a 1 is offered: that bit must be dropped.
    step(1'b1, 1'b1, 1'b1, 8'b11, 2, 1'b1);
    step(1'b1, 1'b1);
    n_checks++;
    if (out !== 1'b0) $display("FAIL cfg_priority first out=%b expected 0", out);
    else n_pass++;
    step(1'b1, 1'b1);
    n_checks++;
    if (out !== 1'b1 || match_cnt !== 16'd1)
      $display("FAIL cfg_priority second out=%b cnt=%0d expected 1/1", out, match_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    #2 arst = 1'b0; #1;
    n_checks++;
    if (match_cnt !== 16'd0 || out !== 1'b0)
      $display("FAIL async_reset cnt=%0d out=%b expected 0/0", match_cnt, out);
    else n_pass++;
    @(posedge clk); #1;
    arst = 1'b1;
    model_reset();
    step(1'b1, 1'b1);
    n_checks++;
    if (out !== 1'b0) $display("FAIL midreset_no_pulse out=%b expected 0", out);
    else n_pass++;
    step(1'b1, 1'b0); step(1'b1, 1'b1);
    n_checks++;
    if (out !== 1'b1) $display("FAIL midreset_pulse out=%b expected 1", out);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1'b1, bit'((i % 2) == 0));
      if (out2) pulses++;
      n_checks++;
      if (match_cnt2 !== 2'(m_cnt2))
        $display("FAIL sat_cnt2 bit%0d got %0d expected %0d", i+1, match_cnt2, m_cnt2);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 5 || match_cnt2 !== 2'd3 || match_cnt !== 16'd5)
      $display("FAIL saturation pulses=%0d cnt2=%0d cnt=%0d expected 5/3/5", pulses, match_cnt2, match_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int l;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        l = ($urandom_range(0, 9) < 7) ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 9));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             8'($urandom), l, 1'($urandom_range(0, 1)));
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      n_checks++;
      if (out !== m_out || cfg_err !== m_err || match_cnt !== 16'(m_cnt) || match_cnt2 !== 2'(m_cnt2))
        $display("FAIL random step%0d out=%b err=%b cnt=%0d cnt2=%0d expected %b/%b/%0d/%0d",
                 i, out, cfg_err, match_cnt, match_cnt2, m_out, m_err, m_cnt, m_cnt2);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_len8_gap();
    test_bad_cfg();
    test_cfg_priority();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
